// File: rtl/tcp_rx_seq_ctrl_pkg.sv
// Shared TCP receive definitions: header flag bit positions, sequence widths
// and the receive sequencer state encoding.
package tcp_rx_seq_ctrl_pkg;

  localparam int SEQ_W  = 32;
  localparam int FLAG_W = 8;

  localparam int FIN_BIT = 0;
  localparam int SYN_BIT = 1;
  localparam int RST_BIT = 2;
  localparam int PSH_BIT = 3;
  localparam int ACK_BIT = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HEAD = 2'd1,
    ACCEPT    = 2'd2,
    DROP      = 2'd3
  } state_t;

endpackage

// File: rtl/tcp_ack_sched.sv
// ACK scheduler: tracks unacknowledged bytes and idle time, and raises an ACK
// request that is held until the TX path accepts it.
module tcp_ack_sched #(
  parameter int LEN_W       = 2,
  parameter int ACK_BYTES   = 1460,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             clear,
  input  logic             add_v,
  input  logic [LEN_W-1:0] add_len,
  input  logic             set_pend,
  input  logic             ack_ready,
  output logic             pend
);

  localparam int              TMR_W     = $clog2(ACK_TIMEOUT + 1);
  localparam logic [15:0]     BYTES_LIM = 16'(ACK_BYTES);
  localparam logic [TMR_W-1:0] TMR_LIM  = TMR_W'(ACK_TIMEOUT);

  logic [15:0]      unacked;
  logic [15:0]      unacked_n;
  logic [16:0]      sum;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_n;
  logic             hs;
  logic             pend_n;

  assign hs = pend & ack_ready;

  // A handshake restarts the count, so a beat in the same cycle is the new total.
  always_comb begin
    sum       = {1'b0, (hs ? 16'd0 : unacked)} + (add_v ? 17'(add_len) : 17'd0);
    unacked_n = sum[16] ? 16'hFFFF : sum[15:0];
    timer_n   = timer;
    if (hs)
      timer_n = '0;
    else if (unacked != 16'd0 && !pend && timer != TMR_LIM)
      timer_n = timer + 1'b1;
    pend_n = set_pend | (pend & ~hs) | (unacked_n >= BYTES_LIM) | (timer_n == TMR_LIM);
  end

  always_ff @(posedge clk) begin
    if (nreset || clear) begin
      unacked <= '0;
      timer   <= '0;
      pend    <= 1'b0;
    end else begin
      unacked <= unacked_n;
      timer   <= timer_n;
      pend    <= pend_n;
    end
  end

endmodule

// File: rtl/tcp_rx_seq_ctrl.sv
// Per-connection TCP receive sequencer: forwards in-order payload, drops
// out-of-order segments, tracks RCV.NXT and schedules ACK requests.
module tcp_rx_seq_ctrl
  import tcp_rx_seq_ctrl_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int LEN_W       = $clog2(DATA_W / 8) + 1,
  parameter int ACK_BYTES   = 1460,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              cfg_v_i,
  input  logic [SEQ_W-1:0]  cfg_rcv_nxt_i,
  input  logic              head_v_i,
  input  logic [SEQ_W-1:0]  seq_i,
  input  logic [FLAG_W-1:0] flag_i,
  input  logic              pl_valid_i,
  input  logic              pl_last_i,
  input  logic [LEN_W-1:0]  pl_len_i,
  input  logic [DATA_W-1:0] pl_data_i,
  output logic              valid_o,
  output logic              start_o,
  output logic              last_o,
  output logic [LEN_W-1:0]  len_o,
  output logic [DATA_W-1:0] data_o,
  output logic              ack_req_o,
  input  logic              ack_ready_i,
  output logic [SEQ_W-1:0]  ack_num_o,
  output logic [SEQ_W-1:0]  rcv_nxt_o,
  output logic              fin_o,
  output logic              rst_o,
  output logic [15:0]       drop_cnt_o
);

  state_t           state;
  logic [SEQ_W-1:0] rcv_nxt;
  logic             fin_lat;
  logic             first;
  logic [15:0]      drop_cnt;

  logic head_eval, head_rst, head_ok, head_bad;
  logic beat_acc, beat_fwd, fin_add;
  logic unused_flags;

  // A header arriving mid-segment abandons it and is judged like a fresh one.
  assign head_eval = !cfg_v_i && head_v_i && (state != IDLE);
  assign head_rst  = head_eval && flag_i[RST_BIT];
  assign head_ok   = head_eval && !flag_i[RST_BIT] && (seq_i == rcv_nxt);
  assign head_bad  = head_eval && !flag_i[RST_BIT] && (seq_i != rcv_nxt);
  assign beat_acc  = !cfg_v_i && !head_v_i && (state == ACCEPT) && pl_valid_i;
  assign beat_fwd  = beat_acc && (pl_len_i != '0);
  assign fin_add   = beat_acc && pl_last_i && fin_lat;

  assign unused_flags = ^{flag_i[ACK_BIT], flag_i[PSH_BIT], flag_i[SYN_BIT], flag_i[FLAG_W-1:5]};

  tcp_ack_sched #(
    .LEN_W       (LEN_W),
    .ACK_BYTES   (ACK_BYTES),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_ack_sched (
    .clk       (clk),
    .nreset    (nreset),
    .clear     (cfg_v_i),
    .add_v     (beat_acc),
    .add_len   (pl_len_i),
    .set_pend  (head_bad | fin_add),
    .ack_ready (ack_ready_i),
    .pend      (ack_req_o)
  );

  always_ff @(posedge clk) begin
    if (nreset) begin
      state    <= IDLE;
      rcv_nxt  <= '0;
      fin_lat  <= 1'b0;
      first    <= 1'b0;
      drop_cnt <= '0;
      valid_o  <= 1'b0;
      start_o  <= 1'b0;
      last_o   <= 1'b0;
      len_o    <= '0;
      data_o   <= '0;
      fin_o    <= 1'b0;
      rst_o    <= 1'b0;
    end else begin
      valid_o <= beat_fwd;
      start_o <= beat_fwd & first;
      last_o  <= beat_fwd & pl_last_i;
      fin_o   <= fin_add;
      rst_o   <= head_rst;
      if (beat_fwd) begin
        len_o  <= pl_len_i;
        data_o <= pl_data_i;
      end
      if (cfg_v_i) begin
        rcv_nxt <= cfg_rcv_nxt_i;
        state   <= WAIT_HEAD;
        fin_lat <= 1'b0;
        first   <= 1'b0;
      end else if (head_eval) begin
        if (head_rst) begin
          state <= IDLE;
        end else if (head_ok) begin
          state   <= ACCEPT;
          fin_lat <= flag_i[FIN_BIT];
          first   <= 1'b1;
        end else begin
          state <= DROP;
          if (drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
        end
      end else if (pl_valid_i) begin
        if (state == ACCEPT) begin
          rcv_nxt <= rcv_nxt + SEQ_W'(pl_len_i) + SEQ_W'(fin_add);
          if (pl_len_i != '0)
            first <= 1'b0;
          if (pl_last_i)
            state <= WAIT_HEAD;
        end else if (state == DROP && pl_last_i) begin
          state <= WAIT_HEAD;
        end
      end
    end
  end

  assign ack_num_o  = rcv_nxt;
  assign rcv_nxt_o  = rcv_nxt;
  assign drop_cnt_o = drop_cnt;

endmodule

// File: doc/tcp_rx_seq_ctrl.md
Name: tcp_rx_seq_ctrl

Overview:
Per-connection receive sequencer placed after the TCP RX header parser and before the transport/application layer. It checks each parsed segment's sequence number against the expected receive pointer (RCV.NXT). In-order payload is forwarded; out-of-order segments are dropped. It schedules outgoing ACK requests to the TCP TX path using a byte threshold and an idle timeout. One instance serves one connection; DATA_W is fixed at 16.

Parameters:
DATA_W, 16, payload bus width in bits (only 16 supported).
LEN_W, $clog2(DATA_W/8)+1, beat length width in bytes (0..DATA_W/8).
SEQ_W, 32, sequence/ack number width.
FLAG_W, 8, TCP flag byte width (CWR..FIN, FIN = bit0, RST = bit2).
ACK_BYTES, 1460, unacked byte count that forces an ACK request.
ACK_TIMEOUT, 1024, cycles with unacked bytes before an ACK request is forced.

Ports:
clk  in  1  clock
nreset  in  1  synchronous reset, active-high: 1 = reset
cfg_v_i  in  1  load initial RCV.NXT (connection established)
cfg_rcv_nxt_i  in  SEQ_W  initial RCV.NXT value
head_v_i  in  1  one-cycle pulse: parsed header valid
seq_i  in  SEQ_W  segment sequence number, valid with head_v_i
flag_i  in  FLAG_W  segment flags, valid with head_v_i
pl_valid_i  in  1  payload beat valid
pl_last_i  in  1  last beat of segment; zero-payload segment = single beat, len 0, last 1
pl_len_i  in  LEN_W  valid bytes in beat
pl_data_i  in  DATA_W  payload bytes
valid_o  out  1  forwarded payload beat valid
start_o  out  1  first forwarded beat of segment
last_o  out  1  last forwarded beat of segment
len_o  out  LEN_W  forwarded beat length
data_o  out  DATA_W  forwarded payload
ack_req_o  out  1  ACK request to TX, held until accepted
ack_ready_i  in  1  TX accepts ACK request
ack_num_o  out  SEQ_W  acknowledgment number, valid with ack_req_o
rcv_nxt_o  out  SEQ_W  current RCV.NXT
fin_o  out  1  one-cycle pulse: in-order FIN consumed
rst_o  out  1  one-cycle pulse: RST received
drop_cnt_o  out  16  dropped-segment counter, saturating

Behaviour:
- States: IDLE, WAIT_HEAD, ACCEPT, DROP. Reset state is IDLE. All outputs are 0 in reset, rcv_nxt included.
- IDLE: ignores all inputs except cfg_v_i.
- cfg_v_i in any state: load RCV.NXT, clear the unacked counter, timer, pending ACK and any in-flight segment, then go to WAIT_HEAD. No further beats of the aborted segment are forwarded.
- WAIT_HEAD, head_v_i:
  - RST set: rst_o pulses, go to IDLE.
  - seq_i == RCV.NXT: latch FIN, go to ACCEPT.
  - otherwise: go to DROP, drop_cnt +1 (saturates at 0xFFFF), set ACK pending (duplicate ACK).
- ACCEPT, each pl_valid_i beat:
  - If len > 0, forward the beat registered with 1-cycle latency. start_o is set on the first forwarded beat; last_o on a beat with pl_last_i.
  - RCV.NXT += len, modulo 2^SEQ_W.
  - Unacked counter += len, saturating at 16 bits.
  - On the pl_last_i beat: if FIN is latched, RCV.NXT += 1 more, fin_o pulses the next cycle, and ACK pending is set. Go to WAIT_HEAD.
  - Zero-payload segment: nothing is forwarded.
- DROP: consume beats without forwarding; return to WAIT_HEAD on pl_last_i.
- head_v_i in ACCEPT/DROP is a protocol error:
  - the current segment is abandoned and last_o is not generated;
  - the new header is evaluated as in WAIT_HEAD in the same cycle.
- ACK scheduling:
  - Pending is set when unacked >= ACK_BYTES, or when the timer reaches ACK_TIMEOUT.
  - The timer counts while unacked > 0 and no ACK is pending.
  - ack_req_o = pending. ack_num_o = registered RCV.NXT, stable while ack_req_o is high but tracking updates until the handshake.
  - Handshake (ack_req_o & ack_ready_i) clears pending, the unacked counter and the timer.
  - Same-cycle handshake and accepted beat: ack_num_o carries the pre-beat RCV.NXT. After the handshake the unacked counter equals that beat's len.
- Wrap: RCV.NXT 0xFFFFFFFF + 2 = 0x00000001; the sequence compare is exact equality.

Decomposition:
- Shared tcp package:
  - flag bit index constants (FIN=0, SYN=1, RST=2, PSH=3, ACK=4);
  - SEQ_W and FLAG_W;
  - a state enum.
- One natural sub-module: tcp_ack_sched, holding the unacked counter, timer, pending flag and handshake.

Test Plan:
- Reset, cfg_rcv_nxt=0x1000, header seq 0x1000 with 3 beats of len 2,2,1 + last → beats forwarded 1 cycle later, start on beat 1, last on beat 3, rcv_nxt_o=0x1005.
- Header seq 0x0FF0 while RCV.NXT=0x1005 → no valid_o, drop_cnt_o=1, ack_req_o=1 with ack_num_o=0x1005. Hold ack_ready_i=0 for 5 cycles → request is held; raise it → request cleared the next cycle.
- ACK_BYTES=4: in-order segments totalling 4 bytes → ack_req_o asserts after the beat reaching 4. Accept with a same-cycle len-2 beat → ack_num_o = pre-beat value, next request after the timeout.
- ACK_TIMEOUT=8: one 1-byte segment, no further traffic → ack_req_o asserts 8 cycles after the beat.
- cfg_rcv_nxt=0xFFFFFFFF, in-order zero-payload FIN segment → no valid_o, fin_o pulse, rcv_nxt_o=0x00000000, ack_req_o=1.
- RST header in WAIT_HEAD → rst_o pulse, state IDLE, later headers ignored. nreset asserted mid-ACCEPT → all outputs 0 the next cycle.
